// File: rtl/dram_resp_queue_pkg.sv
// Shared types and defaults for the DRAM response return path.
// Consumers import with: import dram_resp_queue_pkg::*;
package dram_resp_queue_pkg;

    localparam int DRAM_ID_WIDTH   = 8;
    localparam int SCPAD_DATA_W    = 32;
    localparam int DRAM_RESP_DEPTH = 8;
    localparam int DRAM_NUM_TXN    = 4;

    typedef logic [SCPAD_DATA_W-1:0] scpad_data_t;

    typedef struct packed {
        logic                     write;
        logic [DRAM_ID_WIDTH-1:0] id;
        logic [2:0]               sub_id;
        scpad_data_t              rdata;
    } dram_resp_t;

    // target = num_request+1 (1..8) and done both need four bits
    typedef struct packed {
        logic                     busy;
        logic [DRAM_ID_WIDTH-1:0] id;
        logic [3:0]               target;
        logic [3:0]               done;
    } txn_track_t;

endpackage

// File: rtl/dram_resp_queue_if.sv
// Bundle of the scheduler, DRAM-controller and SRAM-write handshakes around dram_resp_queue.
// master = environment side, slave = the queue itself.
interface dram_resp_queue_if;
    import dram_resp_queue_pkg::*;

    logic                     txn_start_valid;
    logic                     txn_start_ready;
    logic [DRAM_ID_WIDTH-1:0] txn_id;
    logic [2:0]               txn_num_request;
    logic                     txn_write;

    logic                     dram_resp_valid;
    logic                     dram_resp_ready;
    logic                     dram_resp_write;
    logic [DRAM_ID_WIDTH-1:0] dram_resp_id;
    logic [2:0]               dram_resp_sub_id;
    scpad_data_t              dram_resp_rdata;

    logic                     sram_wr_valid;
    logic                     sram_wr_ready;
    logic [DRAM_ID_WIDTH-1:0] sram_wr_id;
    logic [2:0]               sram_wr_sub_id;
    scpad_data_t              sram_wr_data;

    logic                     burst_complete;
    logic                     transaction_complete;
    logic [DRAM_ID_WIDTH-1:0] complete_id;
    logic                     err_unalloc;

    modport master (
        output txn_start_valid, txn_id, txn_num_request, txn_write,
        output dram_resp_valid, dram_resp_write, dram_resp_id, dram_resp_sub_id, dram_resp_rdata,
        output sram_wr_ready,
        input  txn_start_ready, dram_resp_ready,
        input  sram_wr_valid, sram_wr_id, sram_wr_sub_id, sram_wr_data,
        input  burst_complete, transaction_complete, complete_id, err_unalloc
    );

    modport slave (
        input  txn_start_valid, txn_id, txn_num_request, txn_write,
        input  dram_resp_valid, dram_resp_write, dram_resp_id, dram_resp_sub_id, dram_resp_rdata,
        input  sram_wr_ready,
        output txn_start_ready, dram_resp_ready,
        output sram_wr_valid, sram_wr_id, sram_wr_sub_id, sram_wr_data,
        output burst_complete, transaction_complete, complete_id, err_unalloc
    );

endinterface

// File: rtl/dram_resp_queue_fifo.sv
// Synchronous FIFO of dram_resp_t entries; registered count drives full/empty.
// Storage is not reset, only pointers and count.
module dram_resp_fifo
    import dram_resp_queue_pkg::*;
#(
    parameter int DEPTH = DRAM_RESP_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  dram_resp_t               i_data,
    input  logic                     i_pop,
    output dram_resp_t               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    dram_resp_t        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dram_resp_queue.sv
// DRAM response return path: buffers read data / write acks, drains reads to SRAM, retires transactions.
// Optional macro DRAM_RESP_BYPASS_EN: responses arriving at an empty FIFO are presented in their arrival cycle.
module dram_resp_queue
    import dram_resp_queue_pkg::*;
#(
    parameter int DEPTH   = DRAM_RESP_DEPTH,
    parameter int NUM_TXN = DRAM_NUM_TXN,
    parameter int DATA_W  = $bits(scpad_data_t)
) (
    input logic               clk,
    input logic               rst,
    dram_resp_queue_if.slave  io_bus
);

    localparam int SLOT_W = $clog2(NUM_TXN);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    dram_resp_t               w_in;
    dram_resp_t               w_head;
    dram_resp_t               w_sel;
    logic                     w_sel_vld;
    logic                     w_full;
    logic                     w_empty;
    logic [CNT_W-1:0]         w_count;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_bypass;
    logic                     w_retire;
    logic                     w_rd_vld;
    logic [DATA_W-1:0]        w_wr_data;
    logic [SLOT_W-1:0]        w_ret_slot;
    logic [SLOT_W-1:0]        w_start_slot;
    logic                     w_ret_hit;
    logic                     w_ret_last;
    logic                     w_start;
    logic                     w_unused;

    txn_track_t               r_trk [NUM_TXN];
    logic                     r_burst;
    logic                     r_cmp;
    logic [DRAM_ID_WIDTH-1:0] r_cmp_id;
    logic                     r_err;

    assign w_in = '{write:  io_bus.dram_resp_write,
                    id:     io_bus.dram_resp_id,
                    sub_id: io_bus.dram_resp_sub_id,
                    rdata:  io_bus.dram_resp_rdata};

`ifdef DRAM_RESP_BYPASS_EN
    // Write acks always retire on arrival; reads only when the SRAM side can take them now
    assign w_bypass  = w_empty && io_bus.dram_resp_valid &&
                       (io_bus.dram_resp_write || io_bus.sram_wr_ready);
    assign w_sel     = w_empty ? w_in : w_head;
    assign w_sel_vld = w_empty ? io_bus.dram_resp_valid : 1'b1;
`else
    assign w_bypass  = 1'b0;
    assign w_sel     = w_head;
    assign w_sel_vld = !w_empty;
`endif

    assign w_push   = io_bus.dram_resp_valid && !w_full && !w_bypass;
    assign w_pop    = !w_empty && (w_head.write || io_bus.sram_wr_ready);
    assign w_retire = w_pop || w_bypass;
    assign w_rd_vld = w_sel_vld && !w_sel.write;

    dram_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Drained fields are zeroed when no read is presented so idle outputs stay clean
    assign w_wr_data              = w_rd_vld ? w_sel.rdata : '0;
    assign io_bus.dram_resp_ready = !w_full;
    assign io_bus.sram_wr_valid   = w_rd_vld;
    assign io_bus.sram_wr_id      = w_rd_vld ? w_sel.id : '0;
    assign io_bus.sram_wr_sub_id  = w_rd_vld ? w_sel.sub_id : '0;
    assign io_bus.sram_wr_data    = w_wr_data;

    assign w_ret_slot   = w_sel.id[SLOT_W-1:0];
    assign w_start_slot = io_bus.txn_id[SLOT_W-1:0];
    assign w_ret_hit    = r_trk[w_ret_slot].busy && (r_trk[w_ret_slot].id == w_sel.id);
    assign w_ret_last   = (r_trk[w_ret_slot].done + 4'd1) == r_trk[w_ret_slot].target;

    // Readiness comes from registered busy, so a slot freed this cycle still refuses a start
    assign io_bus.txn_start_ready = !r_trk[w_start_slot].busy;
    assign w_start                = io_bus.txn_start_valid && io_bus.txn_start_ready;

    assign io_bus.burst_complete       = r_burst;
    assign io_bus.transaction_complete = r_cmp;
    assign io_bus.complete_id          = r_cmp_id;
    assign io_bus.err_unalloc          = r_err;

    // Transaction kind is implied by the responses themselves; count is observability only
    assign w_unused = ^{io_bus.txn_write, w_count};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TXN; i++) begin
                r_trk[i] <= '0;
            end
            r_burst  <= 1'b0;
            r_cmp    <= 1'b0;
            r_cmp_id <= '0;
            r_err    <= 1'b0;
        end else begin
            r_burst <= 1'b0;
            r_cmp   <= 1'b0;
            if (w_retire) begin
                if (w_ret_hit) begin
                    r_burst <= 1'b1;
                    if (w_ret_last) begin
                        r_cmp                    <= 1'b1;
                        r_cmp_id                 <= w_sel.id;
                        r_trk[w_ret_slot].busy   <= 1'b0;
                        r_trk[w_ret_slot].done   <= 4'd0;
                    end else begin
                        r_trk[w_ret_slot].done   <= r_trk[w_ret_slot].done + 4'd1;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
            // A start only lands on a non-busy slot, which a retire never touches
            if (w_start) begin
                r_trk[w_start_slot] <= '{busy:   1'b1,
                                         id:     io_bus.txn_id,
                                         target: {1'b0, io_bus.txn_num_request} + 4'd1,
                                         done:   4'd0};
            end
        end
    end

endmodule

// File: tb/tb_dram_resp_queue.sv
// Self-checking bench for dram_resp_queue: table of transactions plus hand-written corner sequences.
module tb_dram_resp_queue;
    import dram_resp_queue_pkg::*;

`ifdef DRAM_RESP_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [7:0]  id;
        logic [2:0]  sub;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [7:0] id;
        logic [2:0] nreq;
        logic       wr;
        logic [7:0] exp_cid;
        int         exp_bursts;
        int         exp_beats;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_resp_queue_if bus();

    dram_resp_queue #(.DEPTH(8), .NUM_TXN(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    beat_t      sb[$];
    vec_t       vecs[5];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_burst = 0;
    int         n_cmp   = 0;
    int         n_beats = 0;
    int         last_cmp_cyc = 0;
    int         last_acc_cyc = 0;
    logic [7:0] last_cmp_id  = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sram_wr_valid && bus.sram_wr_ready) begin
                n_beats++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sram_beat: unexpected beat id 0x%0h sub %0d", bus.sram_wr_id, bus.sram_wr_sub_id);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("sram_beat", {bus.sram_wr_id, bus.sram_wr_sub_id, bus.sram_wr_data},
                          {e.id, e.sub, e.data});
                end
            end
            if (bus.burst_complete) n_burst++;
            if (bus.transaction_complete) begin
                n_cmp++;
                last_cmp_cyc = cyc;
                last_cmp_id  = bus.complete_id;
            end
        end
    end

    task automatic start_txn(input logic [7:0] id, input logic [2:0] nreq, input logic wr);
        @(posedge clk); #1;
        bus.txn_start_valid = 1'b1;
        bus.txn_id          = id;
        bus.txn_num_request = nreq;
        bus.txn_write       = wr;
        @(negedge clk); #1;
        check("start_ready", bus.txn_start_ready, 1);
        @(posedge clk); #1;
        bus.txn_start_valid = 1'b0;
    endtask

    task automatic send_resp(input logic [7:0] id, input logic [2:0] sub, input logic wr, input logic [31:0] data);
        bit    ok;
        beat_t b;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.dram_resp_valid  = 1'b1;
        bus.dram_resp_write  = wr;
        bus.dram_resp_id     = id;
        bus.dram_resp_sub_id = sub;
        bus.dram_resp_rdata  = data;
        if (!wr) begin
            b.id = id; b.sub = sub; b.data = data;
            sb.push_back(b);
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (bus.dram_resp_ready) begin
                ok = 1'b1;
                last_acc_cyc = cyc;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_accept_timeout: id 0x%0h never accepted, required within 100 cycles", id);
        end
        @(posedge clk); #1;
        bus.dram_resp_valid = 1'b0;
    endtask

    task automatic wait_cmp(input int target);
        for (int k = 0; k < 80; k++) begin
            if (n_cmp >= target) break;
            @(negedge clk); #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b0, c0, p0;
        bit ok;

        vecs[0] = '{id: 8'h05, nreq: 3'd3, wr: 1'b0, exp_cid: 8'h05, exp_bursts: 4, exp_beats: 4};
        vecs[1] = '{id: 8'h02, nreq: 3'd0, wr: 1'b1, exp_cid: 8'h02, exp_bursts: 1, exp_beats: 0};
        vecs[2] = '{id: 8'h06, nreq: 3'd1, wr: 1'b0, exp_cid: 8'h06, exp_bursts: 2, exp_beats: 2};
        vecs[3] = '{id: 8'h0B, nreq: 3'd7, wr: 1'b0, exp_cid: 8'h0B, exp_bursts: 8, exp_beats: 8};
        vecs[4] = '{id: 8'h00, nreq: 3'd2, wr: 1'b1, exp_cid: 8'h00, exp_bursts: 3, exp_beats: 0};

        bus.txn_start_valid  = 1'b0;
        bus.txn_id           = 8'h00;
        bus.txn_num_request  = 3'd0;
        bus.txn_write        = 1'b0;
        bus.dram_resp_valid  = 1'b0;
        bus.dram_resp_write  = 1'b0;
        bus.dram_resp_id     = 8'h00;
        bus.dram_resp_sub_id = 3'd0;
        bus.dram_resp_rdata  = 32'h0;
        bus.sram_wr_ready    = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("rst_resp_ready", bus.dram_resp_ready, 1);
        check("rst_start_ready", bus.txn_start_ready, 1);
        check("rst_sram_valid", bus.sram_wr_valid, 0);
        check("rst_pulses", {bus.burst_complete, bus.transaction_complete, bus.err_unalloc}, 0);
        check("rst_complete_id", bus.complete_id, 0);

        for (int v = 0; v < 5; v++) begin
            b0 = n_burst; c0 = n_cmp; p0 = n_beats;
            start_txn(vecs[v].id, vecs[v].nreq, vecs[v].wr);
            for (int s = 0; s <= int'(vecs[v].nreq); s++) begin
                send_resp(vecs[v].id, 3'(s), vecs[v].wr, $urandom);
            end
            wait_cmp(c0 + 1);
            check("tbl_cmp_cnt", n_cmp - c0, 1);
            check("tbl_cmp_id", last_cmp_id, vecs[v].exp_cid);
            check("tbl_bursts", n_burst - b0, vecs[v].exp_bursts);
            check("tbl_beats", n_beats - p0, vecs[v].exp_beats);
            check("tbl_cmp_lat", last_cmp_cyc - last_acc_cyc, LAT);
            check("tbl_sb_empty", sb.size(), 0);
        end

        // Fill the FIFO with the SRAM side stalled, then hold a ninth response off
        c0 = n_cmp; p0 = n_beats;
        bus.sram_wr_ready = 1'b0;
        start_txn(8'h04, 3'd7, 1'b0);
        start_txn(8'h01, 3'd0, 1'b0);
        for (int s = 0; s < 8; s++) send_resp(8'h04, 3'(s), 1'b0, 32'hA000_0000 + s);
        check("full_ready_low", bus.dram_resp_ready, 0);
        begin
            beat_t b;
            b.id = 8'h01; b.sub = 3'd0; b.data = 32'hB000_0009;
            sb.push_back(b);
        end
        bus.dram_resp_valid  = 1'b1;
        bus.dram_resp_write  = 1'b0;
        bus.dram_resp_id     = 8'h01;
        bus.dram_resp_sub_id = 3'd0;
        bus.dram_resp_rdata  = 32'hB000_0009;
        repeat (3) begin
            @(negedge clk); #1;
            check("full_hold_ready", bus.dram_resp_ready, 0);
            check("full_head_valid", bus.sram_wr_valid, 1);
        end
        @(posedge clk); #1;
        bus.sram_wr_ready = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (bus.dram_resp_ready) begin ok = 1'b1; break; end
        end
        check("full_ninth_accept", ok, 1);
        @(posedge clk); #1;
        bus.dram_resp_valid = 1'b0;
        wait_cmp(c0 + 2);
        check("full_cmp_cnt", n_cmp - c0, 2);
        check("full_beats", n_beats - p0, 9);
        check("full_last_id", last_cmp_id, 8'h01);
        check("full_sb_empty", sb.size(), 0);

        // A start into a busy slot must leave the existing transaction intact
        c0 = n_cmp;
        start_txn(8'h05, 3'd1, 1'b0);
        @(posedge clk); #1;
        bus.txn_start_valid = 1'b1;
        bus.txn_id          = 8'h01;
        bus.txn_num_request = 3'd0;
        @(negedge clk); #1;
        check("start_busy_ready", bus.txn_start_ready, 0);
        @(posedge clk); #1;
        bus.txn_start_valid = 1'b0;
        send_resp(8'h05, 3'd0, 1'b0, 32'hC0DE_0000);
        send_resp(8'h05, 3'd1, 1'b0, 32'hC0DE_0001);
        wait_cmp(c0 + 1);
        check("busy_cmp_cnt", n_cmp - c0, 1);
        check("busy_cmp_id", last_cmp_id, 8'h05);

        // Response for a slot with nothing open
        check("err_clear", bus.err_unalloc, 0);
        b0 = n_burst; c0 = n_cmp;
        send_resp(8'h03, 3'd0, 1'b1, 32'h0);
        repeat (4) begin @(negedge clk); #1; end
        check("unalloc_no_burst", n_burst - b0, 0);
        check("unalloc_no_cmp", n_cmp - c0, 0);
        check("unalloc_err_set", bus.err_unalloc, 1);
        repeat (5) begin @(negedge clk); #1; end
        check("unalloc_err_sticky", bus.err_unalloc, 1);

        // Reset with queued entries and a busy slot
        start_txn(8'h06, 3'd7, 1'b0);
        bus.sram_wr_ready = 1'b0;
        for (int s = 0; s < 3; s++) send_resp(8'h06, 3'(s), 1'b0, 32'hD000_0000 + s);
        b0 = n_burst; c0 = n_cmp; p0 = n_beats;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        bus.txn_id = 8'h06;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_resp_ready", bus.dram_resp_ready, 1);
        check("mrst_sram_valid", bus.sram_wr_valid, 0);
        check("mrst_slot_free", bus.txn_start_ready, 1);
        check("mrst_err_clear", bus.err_unalloc, 0);
        bus.sram_wr_ready = 1'b1;
        repeat (4) begin @(negedge clk); #1; end
        check("mrst_no_burst", n_burst - b0, 0);
        check("mrst_no_cmp", n_cmp - c0, 0);
        check("mrst_no_beats", n_beats - p0, 0);

        c0 = n_cmp;
        start_txn(8'h06, 3'd0, 1'b0);
        send_resp(8'h06, 3'd0, 1'b0, 32'h600D_F00D);
        wait_cmp(c0 + 1);
        check("post_rst_cmp_id", last_cmp_id, 8'h06);

`ifdef DRAM_RESP_BYPASS_EN
        start_txn(8'h02, 3'd0, 1'b0);
        @(posedge clk); #1;
        begin
            beat_t b;
            b.id = 8'h02; b.sub = 3'd0; b.data = 32'hBEEF_0002;
            sb.push_back(b);
        end
        bus.dram_resp_valid  = 1'b1;
        bus.dram_resp_write  = 1'b0;
        bus.dram_resp_id     = 8'h02;
        bus.dram_resp_sub_id = 3'd0;
        bus.dram_resp_rdata  = 32'hBEEF_0002;
        #1;
        check("byp_same_cycle", bus.sram_wr_valid, 1);
        @(posedge clk); #1;
        bus.dram_resp_valid = 1'b0;
        check("byp_not_queued", bus.sram_wr_valid, 0);
        check("byp_ready", bus.dram_resp_ready, 1);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
